digit_entry_buffer: RTL

Keypad digit entry buffer for the Bulls and Cows datapath. Takes the ten one-hot decimal key lines, detects key presses, encodes each press to 4-bit BCD and assembles `NUM_DIGITS` digits into a packed guess word. The word is offered to the game core over a valid/ready handshake, with clear and backspace editing while the guess is being entered.

---
 rtl/digit_entry_buffer.sv | 77 +++++++
 1 files changed

// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer: keypad press detect, BCD encode and guess assembly with valid/ready offer.
// Optional DIGIT_UNIQUE_EN rejects a digit already present in the guess.
module digit_entry_buffer #(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              key,
  input  logic                    clr,
  input  logic                    del,
  input  logic                    guess_ready,
  output logic                    guess_valid,
  output logic [4*NUM_DIGITS-1:0] guess,
  output logic [CNT_W-1:0]        count,
  output logic                    key_err
);
  typedef enum logic {ENTRY, FULL} state_t;
  state_t                  st, st_n;
  logic [9:0]              key_q;
  logic [CNT_W-1:0]        cnt_n;
  logic [4*NUM_DIGITS-1:0] g_n;
  logic                    err_n, press, multi, dup;
  logic [3:0]              d;
  assign press       = |key && !(|key_q);
  assign multi       = !$onehot(key);
  assign guess_valid = st == FULL;
  always_comb begin
    d   = 4'd0;
    dup = 1'b0;
    for (int i = 0; i < 10; i++)
      if (key[i]) d = 4'(i);
`ifdef DIGIT_UNIQUE_EN
    for (int i = 0; i < NUM_DIGITS; i++)
      if (CNT_W'(i) < count && guess[4*(NUM_DIGITS-1-i) +: 4] == d) dup = 1'b1;
`endif
  end
  always_comb begin
    st_n  = st;
    cnt_n = count;
    g_n   = guess;
    err_n = 1'b0;
    if (clr || (st == FULL && guess_ready)) begin
      st_n  = ENTRY;
      cnt_n = '0;
      g_n   = '0;
    end else if (st == ENTRY && del) begin
      if (count != '0) begin
        cnt_n = count - CNT_W'(1);
        for (int i = 0; i < NUM_DIGITS; i++)
          if (CNT_W'(i + 1) == count) g_n[4*(NUM_DIGITS-1-i) +: 4] = 4'd0;
      end
    end else if (st == ENTRY && press) begin
      if (multi || dup) err_n = 1'b1;
      else begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (CNT_W'(i) == count) g_n[4*(NUM_DIGITS-1-i) +: 4] = d;
        cnt_n = count + CNT_W'(1);
        st_n  = count == CNT_W'(NUM_DIGITS - 1) ? FULL : ENTRY;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st      <= ENTRY;
      key_q   <= '0;
      count   <= '0;
      guess   <= '0;
      key_err <= 1'b0;
    end else begin
      st      <= st_n;
      key_q   <= key;
      count   <= cnt_n;
      guess   <= g_n;
      key_err <= err_n;
    end
endmodule
